// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide engine: radix-2^MUL_STEP shift-add multiplier
// and radix-2 restoring divider sharing one FSM, with ISA divide corner cases resolved at start.
module muldiv_iter #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            cancel_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_STEP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

    state_t r_state, w_state_next;

    logic [2:0]        r_op;
    logic              r_neg_p, r_neg_q, r_neg_r;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_dvs;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_result;

    // Start decode: operand signedness, magnitudes and divide fast path
    logic            w_start, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic            w_div0, w_ovf, w_fast;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_fast_res;

    assign w_start    = start_i && !cancel_i && (r_state == S_IDLE || r_state == S_DONE);
    assign w_a_signed = !((op_i == 3'b011) || (op_i[2] && op_i[0]));
    assign w_b_signed = w_a_signed && (op_i != 3'b010);
    assign w_a_neg    = w_a_signed && opa_i[XLEN-1];
    assign w_b_neg    = w_b_signed && opb_i[XLEN-1];
    assign w_mag_a    = w_a_neg ? -opa_i : opa_i;
    assign w_mag_b    = w_b_neg ? -opb_i : opb_i;
    assign w_div0     = op_i[2] && (opb_i == '0);
    assign w_ovf      = op_i[2] && !op_i[0] && (opa_i == MIN_NEG) && (&opb_i);
    assign w_fast     = w_div0 || w_ovf;
    assign w_fast_res = w_div0 ? (op_i[1] ? opa_i : '1) : (op_i[1] ? '0 : opa_i);

    // Multiply step: MUL_STEP partial products added into the upper half, then shift right
    logic [XLEN+MUL_STEP-1:0] w_pp [MUL_STEP];
    logic [XLEN+MUL_STEP-1:0] w_sum;
    logic [2*XLEN-1:0]        w_acc_next;

    generate
        for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
            assign w_pp[gi] = r_acc[gi] ? ({{MUL_STEP{1'b0}}, r_mcand} << gi) : '0;
        end
    endgenerate

    always_comb begin
        w_sum = {{MUL_STEP{1'b0}}, r_acc[2*XLEN-1:XLEN]};
        for (int i = 0; i < MUL_STEP; i++) begin
            w_sum = w_sum + w_pp[i];
        end
    end

    assign w_acc_next = {w_sum, r_acc[XLEN-1:MUL_STEP]};

    // Restoring divide step; the dividend shifts out of r_quo as quotient bits shift in
    logic [XLEN+1:0] w_shift, w_diff;
    logic            w_ge;

    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_ge    = w_shift >= {2'b00, r_dvs};
    assign w_diff  = w_shift - {2'b00, r_dvs};

    // Sign fixup and result selection
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem_lo, w_remf, w_fix_res;

    assign w_prod   = r_neg_p ? -r_acc : r_acc;
    assign w_quo    = r_neg_q ? -r_quo : r_quo;
    assign w_rem_lo = r_rem[XLEN-1:0];
    assign w_remf   = r_neg_r ? -w_rem_lo : w_rem_lo;

    always_comb begin
        case (r_op)
            3'b000:                 w_fix_res = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo;
            default:                w_fix_res = w_remf;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_next = S_IDLE;
                if (w_start) begin
                    w_state_next = w_fast ? S_DONE : (op_i[2] ? S_DIV : S_MUL);
                end
            end
            S_MUL:   if (r_cnt == MUL_LAST) w_state_next = S_FIXUP;
            S_DIV:   if (r_cnt == DIV_LAST) w_state_next = S_FIXUP;
            S_FIXUP: w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
        if (cancel_i) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_neg_p  <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_dvs    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else if (w_start) begin
            r_op    <= op_i;
            r_neg_p <= w_a_neg ^ w_b_neg;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= '0;
            r_mcand <= w_mag_a;
            r_acc   <= {{XLEN{1'b0}}, w_mag_b};
            r_dvs   <= w_mag_b;
            r_quo   <= w_mag_a;
            r_rem   <= '0;
            if (w_fast) begin
                r_result <= w_fast_res;
            end
        end else begin
            case (r_state)
                S_MUL: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_DIV: begin
                    r_rem <= w_ge ? w_diff[XLEN:0] : w_shift[XLEN:0];
                    r_quo <= {r_quo[XLEN-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIXUP: begin
                    if (!cancel_i) begin
                        r_result <= w_fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIXUP);
    assign valid_o  = (r_state == S_DONE);
    assign result_o = r_result;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: 32-bit instance with hand-computed vectors and timing,
// plus three 64-bit instances (MUL_STEP 1/2/8) checked against native arithmetic.
module tb_muldiv_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_i, cancel_i;
    logic [2:0]  op_i;
    logic [31:0] opa_i, opb_i;
    logic        busy_o, valid_o;
    logic [31:0] result_o;

    logic        start64;
    logic [2:0]  op64;
    logic [63:0] a64, b64;
    logic        busy64  [3];
    logic        valid64 [3];
    logic [63:0] res64   [3];

    int n_asserts = 0;
    int n_fail    = 0;

    muldiv_iter #(.XLEN(32), .MUL_STEP(4)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .cancel_i(cancel_i), .op_i(op_i),
        .opa_i(opa_i), .opb_i(opb_i), .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
    );

    muldiv_iter #(.XLEN(64), .MUL_STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .start_i(start64), .cancel_i(1'b0), .op_i(op64),
        .opa_i(a64), .opb_i(b64), .busy_o(busy64[0]), .valid_o(valid64[0]), .result_o(res64[0])
    );
    muldiv_iter #(.XLEN(64), .MUL_STEP(2)) u_s2 (
        .clk(clk), .rst(rst), .start_i(start64), .cancel_i(1'b0), .op_i(op64),
        .opa_i(a64), .opb_i(b64), .busy_o(busy64[1]), .valid_o(valid64[1]), .result_o(res64[1])
    );
    muldiv_iter #(.XLEN(64), .MUL_STEP(8)) u_s8 (
        .clk(clk), .rst(rst), .start_i(start64), .cancel_i(1'b0), .op_i(op64),
        .opa_i(a64), .opb_i(b64), .busy_o(busy64[2]), .valid_o(valid64[2]), .result_o(res64[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Launch one op on the 32-bit unit and measure latency; optional stray start at cycle poke
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int poke);
        int lat;
        int nbusy;
        lat   = 0;
        nbusy = 0;
        start_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = 3'b101; opa_i = 32'hDEAD_BEEF; opb_i = 32'h0;
        for (int e = 1; e <= 60; e++) begin
            if (valid_o) begin
                lat = e;
                break;
            end
            if (busy_o) nbusy++;
            if (e == poke) begin
                start_i = 1'b1; op_i = 3'b101; opa_i = 32'd100; opb_i = 32'd7;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        $display("op %s: op=%0d a=%h b=%h -> result %h latency %0d", tag, op, a, b, result_o, lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(result_o), 64'(exp));
        check({tag, " busy cycles"}, 64'(nbusy), 64'(exp_lat - 1));
        check({tag, " busy at valid"}, 64'(busy_o), 64'd0);
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        check({tag, " valid after done"}, 64'(valid_o), 64'd0);
    endtask

    function automatic logic [63:0] ref64(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [127:0] ua, ub, sa, sb, p;
        logic         ovf;
        logic [63:0]  r;
        ua  = {64'd0, a};
        ub  = {64'd0, b};
        sa  = {{64{a[63]}}, a};
        sb  = {{64{b[63]}}, b};
        ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        r   = '0;
        case (op)
            3'd0: begin p = ua * ub; r = p[63:0]; end
            3'd1: begin p = sa * sb; r = p[127:64]; end
            3'd2: begin p = sa * ub; r = p[127:64]; end
            3'd3: begin p = ua * ub; r = p[127:64]; end
            3'd4: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf ? a : 64'($signed(a) / $signed(b));
            3'd5: r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 64'd0 : 64'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Same operands to all three 64-bit instances; each has its own expected latency
    task automatic run64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        int          lat [3];
        logic [63:0] got [3];
        int          steps [3];
        logic [63:0] exp;
        logic        fast;
        int          exp_lat;
        steps = '{1, 2, 8};
        lat   = '{0, 0, 0};
        got   = '{64'd0, 64'd0, 64'd0};
        exp   = ref64(op, a, b);
        fast  = op[2] && ((b == 0) || (!op[0] && a == 64'h8000_0000_0000_0000 &&
                                       b == 64'hFFFF_FFFF_FFFF_FFFF));
        start64 = 1'b1; op64 = op; a64 = a; b64 = b;
        @(posedge clk); #1;
        start64 = 1'b0;
        for (int e = 1; e <= 80; e++) begin
            for (int k = 0; k < 3; k++) begin
                if (valid64[k] && lat[k] == 0) begin
                    lat[k] = e;
                    got[k] = res64[k];
                end
            end
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            exp_lat = fast ? 1 : (op[2] ? 66 : 64 / steps[k] + 2);
            $display("x64 step%0d: op=%0d a=%h b=%h -> result %h latency %0d",
                     steps[k], op, a, b, got[k], lat[k]);
            check($sformatf("x64 step%0d op%0d latency", steps[k], op), 64'(lat[k]), 64'(exp_lat));
            check($sformatf("x64 step%0d op%0d result", steps[k], op), got[k], exp);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int          nvalid;
        logic [63:0] ra, rb;
        rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; op_i = '0; opa_i = '0; opb_i = '0;
        start64 = 1'b0; op64 = '0; a64 = '0; b64 = '0;
        #12;
        check("reset result", 64'(result_o), 64'd0);
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset valid", 64'(valid_o), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post reset valid", 64'(valid_o), 64'd0);

        run_op("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 10, 0);       idle_cycle("MUL");
        run_op("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 10, 0); idle_cycle("MULH");
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 0); idle_cycle("MULHSU");
        run_op("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 10, 0); idle_cycle("MULHU");
        run_op("DIV", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);       idle_cycle("DIV");
        run_op("REM", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);       idle_cycle("REM");
        run_op("DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 34, 0);                   idle_cycle("DIVU");
        run_op("REMU", 3'b111, 32'd100, 32'd7, 32'd2, 34, 0);                    idle_cycle("REMU");
        run_op("DIVU by 0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);          idle_cycle("DIVU0");
        run_op("REM by 0", 3'b110, 32'd5, 32'd0, 32'd5, 1, 0);                   idle_cycle("REM0");
        run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0); idle_cycle("DIVOVF");
        run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);    idle_cycle("REMOVF");

        run_op("start while busy", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 10, 3);
        idle_cycle("start while busy");

        run_op("b2b first", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 10, 0);
        run_op("b2b second", 3'b101, 32'd100, 32'd7, 32'd14, 34, 0);
        idle_cycle("b2b");

        // Cancel at edge 5 of a divide; old result 14 must survive
        start_i = 1'b1; op_i = 3'b101; opa_i = 32'hFFFF_FFFF; opb_i = 32'd3;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cancel_i = 1'b1; start_i = 1'b1; op_i = 3'b011;
        @(posedge clk); #1;
        cancel_i = 1'b0; start_i = 1'b0;
        check("cancel busy", 64'(busy_o), 64'd0);
        check("cancel valid", 64'(valid_o), 64'd0);
        nvalid = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid_o) nvalid++;
            @(posedge clk); #1;
        end
        $display("op cancel: valid pulses %0d result %h", nvalid, result_o);
        check("cancel no valid", 64'(nvalid), 64'd0);
        check("cancel result held", 64'(result_o), 64'd14);

        // Cancel wins over a same-cycle start in IDLE
        cancel_i = 1'b1; start_i = 1'b1; op_i = 3'b000; opa_i = 32'd3; opb_i = 32'd3;
        @(posedge clk); #1;
        cancel_i = 1'b0; start_i = 1'b0;
        check("cancel+start busy", 64'(busy_o), 64'd0);
        check("cancel+start valid", 64'(valid_o), 64'd0);

        // Asynchronous reset mid-multiply
        start_i = 1'b1; op_i = 3'b000; opa_i = 32'd7; opb_i = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        $display("op reset mid-MUL: busy %0d valid %0d result %h", busy_o, valid_o, result_o);
        check("midreset busy", 64'(busy_o), 64'd0);
        check("midreset valid", 64'(valid_o), 64'd0);
        check("midreset result", 64'(result_o), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("after reset valid", 64'(valid_o), 64'd0);
        run_op("MUL after reset", 3'b000, 32'h1234_5678, 32'h10, 32'h2345_6780, 10, 0);
        idle_cycle("MUL after reset");

        // 64-bit regression: random, small/zero divisors, most-negative/-1 operands
        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i / 8 == 1) rb = 64'(i % 3);
            if (i / 8 == 2) begin
                ra = 64'h8000_0000_0000_0000;
                rb = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            run64(3'(i % 8), ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
